// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU and a debug/loader port.
// Arbitrates, latches the winning command, issues a one-cycle mem_en strobe and
// returns a one-cycle ack MEM_LAT cycles later, one access at a time.
// Optional build macro ARB_CPU_PRIO_EN: fixed priority (CPU always wins ties).
// Without it, ties are resolved round-robin.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic [1:0]    cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic [1:0]    dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic [1:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        BUSY_CPU = 2'b01,
        BUSY_DBG = 2'b10
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          grant_cpu;
    logic          grant_dbg;

`ifdef ARB_CPU_PRIO_EN
    // Fixed priority: DBG only gets the port when the CPU is not asking
    always_comb begin
        grant_cpu = cpu_req;
        grant_dbg = dbg_req & ~cpu_req;
    end
`else
    logic last_grant_dbg;

    // Round-robin: on a tie the requester not granted last time wins
    always_comb begin
        grant_cpu = cpu_req & (~dbg_req | last_grant_dbg);
        grant_dbg = dbg_req & (~cpu_req | ~last_grant_dbg);
    end

    // Remember who was granted last; reset favours the CPU on the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_dbg <= 1'b1;
        end else if (state == IDLE) begin
            if (grant_cpu)
                last_grant_dbg <= 1'b0;
            else if (grant_dbg)
                last_grant_dbg <= 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: grant from IDLE, return to IDLE when the countdown expires
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (grant_cpu)
                    state_next = BUSY_CPU;
                else if (grant_dbg)
                    state_next = BUSY_DBG;
                else
                    state_next = IDLE;
            end
            BUSY_CPU: state_next = (cnt == '0) ? IDLE : BUSY_CPU;
            BUSY_DBG: state_next = (cnt == '0) ? IDLE : BUSY_DBG;
            default:  state_next = IDLE;
        endcase
    end

    // Latency counter: loaded only on a grant, counts down to zero, never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_cpu | grant_dbg)
                cnt <= LAT;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Command latch: capture the winner's command, hold it through the BUSY period
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE) begin
            if (grant_cpu) begin
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (grant_dbg) begin
                mem_we    <= dbg_we;
                mem_addr  <= dbg_addr;
                mem_wdata <= dbg_wdata;
            end
        end
    end

    // Outputs: strobe on the first BUSY cycle (cnt still full), ack when cnt hits zero
    always_comb begin
        mem_en    = (state != IDLE) && (cnt == LAT);
        cpu_ack   = (state == BUSY_CPU) && (cnt == '0);
        dbg_ack   = (state == BUSY_DBG) && (cnt == '0);
        cpu_rdata = cpu_ack ? mem_rdata : '0;
        dbg_rdata = dbg_ack ? mem_rdata : '0;
        owner     = state;
    end

endmodule
